// File: rtl/clock_pkg.sv
// Shared types and constants for the settable HH:MM clock.
// CLOCK_ALARM_EN adds the two alarm-edit states to the mode cycle.
package clock_pkg;

    typedef enum logic [2:0] {
        RUN    = 3'd0,
        SET_H  = 3'd1,
        SET_M  = 3'd2,
        SET_AH = 3'd3,
        SET_AM = 3'd4
    } state_t;

    typedef logic [3:0] bcd_t;

    // Limits are BCD-encoded so they compare directly against the digit pairs.
    localparam logic [7:0] HOUR_MAX = 8'h23;
    localparam logic [7:0] MIN_MAX  = 8'h59;
    localparam logic [7:0] SEC_MAX  = 8'h59;

    function automatic state_t next_mode(state_t s);
        case (s)
            RUN:     return SET_H;
            SET_H:   return SET_M;
`ifdef CLOCK_ALARM_EN
            SET_M:   return SET_AH;
            SET_AH:  return SET_AM;
`endif
            default: return RUN;
        endcase
    endfunction

    function automatic logic [3:0] les_for(state_t s, logic ph);
        case (s)
            SET_H, SET_AH: return {ph, ph, 2'b00};
            SET_M, SET_AM: return {2'b00, ph, ph};
            default:       return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD counter with increment, clear, programmable BCD maximum and carry-out.
// value_next exposes the upcoming value so the parent can register derived outputs in step.
module bcd2_counter
    import clock_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       clr,
    input  logic [7:0] max_val,
    output logic [7:0] value,
    output logic [7:0] value_next,
    output logic       carry
);

    bcd_t tens;
    bcd_t ones;
    logic at_max;

    assign tens   = value[7:4];
    assign ones   = value[3:0];
    assign at_max = (value == max_val);
    assign carry  = inc && !clr && at_max;

    always_comb begin
        value_next = value;
        if (clr) begin
            value_next = 8'h00;
        end else if (inc) begin
            if (at_max) begin
                value_next = 8'h00;
            end else if (ones == 4'd9) begin
                value_next = {tens + 4'd1, 4'd0};
            end else begin
                value_next = {tens, ones + 4'd1};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= 8'h00;
        end else begin
            value <= value_next;
        end
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// 24-hour BCD clock with button-driven hour/minute setting and blinking digit mask.
// Define CLOCK_ALARM_EN to add alarm editing, alarm_on toggle and alarm_hit.
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int TICKS_PER_SEC = 10,
    parameter int BLINK_TICKS   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick_100ms,
    input  logic        btn_mode,
    input  logic        btn_inc,
    output logic [15:0] time_bcd,
    output logic [3:0]  les,
    output logic [1:0]  mode,
    output logic        alarm_hit
);

    localparam int SUB_W   = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int BLINK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [SUB_W-1:0]   SUB_LAST   = SUB_W'(TICKS_PER_SEC - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TICKS - 1);

    state_t             state;
    state_t             state_next;
    logic [SUB_W-1:0]   sub_cnt;
    logic [SUB_W-1:0]   sub_next;
    logic [BLINK_W-1:0] blink_cnt;
    logic [BLINK_W-1:0] blink_cnt_next;
    logic               blink_ph;
    logic               blink_ph_next;

    logic running;
    logic advance;
    logic sub_wrap;
    logic inc_ok;
    logic leave_set_m;

    logic [7:0] sec_bcd;
    logic [7:0] sec_next;
    logic       sec_carry;
    logic [7:0] min_bcd;
    logic [7:0] min_next;
    logic       min_carry;
    logic [7:0] hour_bcd;
    logic [7:0] hour_next;
    logic       hour_carry;

    logic [15:0] disp_next;
    logic        hit_next;

    // Time only stands still while the clock itself is being edited.
    assign running     = (state != SET_H) && (state != SET_M);
    assign advance     = running && tick_100ms;
    assign sub_wrap    = advance && (sub_cnt == SUB_LAST);
    assign inc_ok      = btn_inc && !btn_mode;
    assign leave_set_m = btn_mode && (state == SET_M);
    assign state_next  = btn_mode ? next_mode(state) : state;

    always_comb begin
        sub_next = sub_cnt;
        if (leave_set_m) begin
            sub_next = '0;
        end else if (advance) begin
            sub_next = sub_wrap ? '0 : sub_cnt + SUB_W'(1);
        end
    end

    always_comb begin
        blink_cnt_next = blink_cnt;
        blink_ph_next  = blink_ph;
        if (btn_mode) begin
            blink_cnt_next = '0;
            blink_ph_next  = 1'b0;
        end else if (tick_100ms) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt_next = '0;
                blink_ph_next  = ~blink_ph;
            end else begin
                blink_cnt_next = blink_cnt + BLINK_W'(1);
            end
        end
    end

    bcd2_counter u_sec (
        .clk        (clk),
        .rst        (rst),
        .inc        (sub_wrap),
        .clr        (leave_set_m),
        .max_val    (SEC_MAX),
        .value      (sec_bcd),
        .value_next (sec_next),
        .carry      (sec_carry)
    );

    // Minute edits wrap on their own; only running carries reach the hours.
    bcd2_counter u_min (
        .clk        (clk),
        .rst        (rst),
        .inc        (sec_carry || ((state == SET_M) && inc_ok)),
        .clr        (1'b0),
        .max_val    (MIN_MAX),
        .value      (min_bcd),
        .value_next (min_next),
        .carry      (min_carry)
    );

    bcd2_counter u_hour (
        .clk        (clk),
        .rst        (rst),
        .inc        ((running && min_carry) || ((state == SET_H) && inc_ok)),
        .clr        (1'b0),
        .max_val    (HOUR_MAX),
        .value      (hour_bcd),
        .value_next (hour_next),
        .carry      (hour_carry)
    );

`ifdef CLOCK_ALARM_EN
    logic [7:0] al_hour_bcd;
    logic [7:0] al_hour_next;
    logic       al_hour_carry;
    logic [7:0] al_min_bcd;
    logic [7:0] al_min_next;
    logic       al_min_carry;
    logic       alarm_on;
    logic       unused_bits;

    bcd2_counter u_al_hour (
        .clk        (clk),
        .rst        (rst),
        .inc        ((state == SET_AH) && inc_ok),
        .clr        (1'b0),
        .max_val    (HOUR_MAX),
        .value      (al_hour_bcd),
        .value_next (al_hour_next),
        .carry      (al_hour_carry)
    );

    bcd2_counter u_al_min (
        .clk        (clk),
        .rst        (rst),
        .inc        ((state == SET_AM) && inc_ok),
        .clr        (1'b0),
        .max_val    (MIN_MAX),
        .value      (al_min_bcd),
        .value_next (al_min_next),
        .carry      (al_min_carry)
    );

    assign disp_next = ((state_next == SET_AH) || (state_next == SET_AM)) ?
                       {al_hour_next, al_min_next} : {hour_next, min_next};
    assign hit_next  = (state == RUN) && alarm_on &&
                       (hour_bcd == al_hour_bcd) && (min_bcd == al_min_bcd);
    assign unused_bits = ^{sec_bcd, sec_next, hour_carry, al_hour_carry, al_min_carry};
`else
    logic unused_bits;

    assign disp_next   = {hour_next, min_next};
    assign hit_next    = 1'b0;
    assign unused_bits = ^{sec_bcd, sec_next, hour_carry, hour_bcd, min_bcd};
`endif

    // Outputs are registered from next-state values so they line up with the counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            mode      <= 2'd0;
            les       <= 4'b0000;
            time_bcd  <= 16'h0000;
            alarm_hit <= 1'b0;
            sub_cnt   <= '0;
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
`ifdef CLOCK_ALARM_EN
            alarm_on  <= 1'b0;
`endif
        end else begin
            state     <= state_next;
            mode      <= state_next[1:0];
            les       <= les_for(state_next, blink_ph_next);
            time_bcd  <= disp_next;
            alarm_hit <= hit_next;
            sub_cnt   <= sub_next;
            blink_cnt <= blink_cnt_next;
            blink_ph  <= blink_ph_next;
`ifdef CLOCK_ALARM_EN
            if ((state == RUN) && inc_ok) begin
                alarm_on <= ~alarm_on;
            end
`endif
        end
    end

endmodule

// File: doc/clock_set_ctrl.md
CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

Interface
REQ-001 Parameter TICKS_PER_SEC, default 10, tick_100ms pulses per second.
REQ-002 Parameter BLINK_TICKS, default 5, tick_100ms pulses per blink half-period.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 tick_100ms  input  1  one-cycle timebase pulse.
REQ-006 btn_mode  input  1  one-cycle pulse, already debounced; advances mode.
REQ-007 btn_inc  input  1  one-cycle pulse, already debounced; increments selected field.
REQ-008 time_bcd  output  16  {H tens, H ones, M tens, M ones}, registered BCD.
REQ-009 les  output  4  per-digit blank mask for display, bit 3 = H tens; 1 = blanked.
REQ-010 mode  output  2  current state encoding.
REQ-011 alarm_hit  output  1  alarm active level; constant 0 without ALARM_EN.

Function
REQ-012 States: RUN=0, SET_H=1, SET_M=2; with ALARM_EN also SET_AH and SET_AM (see REQ-027).
REQ-013 btn_mode: RUN->SET_H->SET_M->RUN; transition takes effect the cycle after the pulse.
REQ-014 RUN: each tick increments sub-second counter 0..TICKS_PER_SEC-1; wrap increments seconds 0..59.
REQ-015 Seconds wrap 59->0 increments minutes; 59 min -> 00 carries into hours; 23:59 -> 00:00.
REQ-016 SET_H/SET_M: time frozen; sub-second and seconds counters held.
REQ-017 SET_H: btn_inc increments hours mod 24 (23->00); no effect on minutes.
REQ-018 SET_M: btn_inc increments minutes mod 60 (59->00); no carry into hours.
REQ-019 SET_M->RUN clears seconds and sub-second counters to 0.
REQ-020 btn_mode and btn_inc in same cycle: mode change wins; inc ignored.
REQ-021 btn_inc and tick in same cycle in a SET state: increment applied; tick advances blink only.
REQ-022 Blink phase toggles every BLINK_TICKS ticks in every state; reset to 0 on each state change.
REQ-023 les: RUN = 0000; SET_H = {ph,ph,0,0}; SET_M = {0,0,ph,ph}; ph = blink phase.
REQ-024 All outputs registered; time_bcd reflects an event one cycle after it.
REQ-025 Every BCD digit SHALL remain in 0..9 at all times; H tens 0..2, M tens 0..5.

Reset
REQ-026 rst: state RUN, time_bcd 16'h0000, seconds 0, sub-second 0, blink phase 0, les 0000, mode 0, alarm_hit 0; alarm register 00:00 and alarm_on 0 when compiled in; rst wins over all inputs, including mid-edit.

Configuration
REQ-027 CLOCK_ALARM_EN defined: mode cycle RUN->SET_H->SET_M->SET_AH->SET_AM->RUN (encodings 3 and 4 use a 3-bit internal state; mode output = state[1:0]).
REQ-028 SET_AH/SET_AM edit alarm hours/minutes as REQ-017/018; time_bcd shows alarm value, les blinks as SET_H/SET_M; time keeps running.
REQ-029 With CLOCK_ALARM_EN, btn_inc in RUN toggles alarm_on; alarm_hit = RUN and alarm_on and time HH:MM equals alarm HH:MM (registered).
REQ-030 Without CLOCK_ALARM_EN: btn_inc in RUN ignored, no alarm registers, alarm_hit tied 0.

Structure
REQ-031 Package clock_pkg: state enum, 4-bit BCD digit typedef, constants HOUR_MAX=23, MIN_MAX=59, SEC_MAX=59.
REQ-032 Sub-module bcd2_counter: two-digit BCD counter with inc, clear, programmable max, carry-out; instanced for seconds, minutes, hours and alarm fields.

Verification
REQ-033 Reset, then 600 ticks in RUN -> time_bcd 16'h0001, seconds 0.
REQ-034 Preload 23:59:59, TICKS_PER_SEC more ticks -> time_bcd 16'h0000.
REQ-035 btn_mode, 25 btn_inc, btn_mode, 61 btn_inc, btn_mode -> time_bcd 16'h0101, mode 0, seconds 0.
REQ-036 In SET_M, btn_mode and btn_inc same cycle -> mode 0, minutes unchanged.
REQ-037 In SET_H, 10 ticks -> les sequence 0000 (5 ticks) then 1100 (5 ticks); rst mid-edit -> RUN, 16'h0000.
REQ-038 CLOCK_ALARM_EN: alarm 00:01, alarm_on set, 600 ticks -> alarm_hit 1 for 60 s, then 0.
